// File: rtl/fsk_tx_frame_scheduler.sv
// ============================================================================
// Module: fsk_tx_frame_scheduler
//
// Purpose:
//   Shares one FSK serial transmit line between NUM_REQ requesters. Each
//   requester offers a 4-bit nibble. The block arbitrates between the
//   requesters and serialises the winning nibble as one frame:
//       header 1,1,1 | data bit0..bit3 (LSB first) | even parity | GAP_BITS x 0
//   Every serial bit lasts BIT_DIV clk cycles. The output feeds the FSK
//   modulator, and the framing matches the receive-side frame decoder.
//
// Build option:
//   FSK_TX_FIXED_PRIO_EN - when defined, arbitration is fixed priority (the
//                          lowest valid index wins) and there is no
//                          round-robin pointer. When undefined (default), the
//                          search is round-robin, starting at the requester
//                          after the previous winner.
//
// Parameters:
//   NUM_REQ   - number of requesters, 2..8
//   BIT_DIV   - clk cycles per serial bit, >= 2
//   GAP_BITS  - idle zero bits after each frame, >= 1
//
// Ports:
//   clk           in   clock, all logic on posedge
//   reset         in   synchronous, active-low reset
//   i_req_valid   in   [NUM_REQ]   per-requester valid, held until ready
//   i_req_data    in   [4*NUM_REQ] nibble of requester i at [4i+3:4i]
//   o_req_ready   out  [NUM_REQ]   one-cycle accept pulse, one-hot or zero
//   o_tx_bit      out  serial line to the modulator, idles 0
//   o_tx_active   out  high from the first header bit to the end of parity
//   o_bit_strobe  out  high on the last clk of every bit period while busy
//   o_grant_id    out  [clog2(NUM_REQ)] requester that owns the frame
//   o_busy        out  high whenever the scheduler is not idle
// ============================================================================
module fsk_tx_frame_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int BIT_DIV  = 8,
    parameter int GAP_BITS = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [4*NUM_REQ-1:0]       i_req_data,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic                       o_tx_bit,
    output logic                       o_tx_active,
    output logic                       o_bit_strobe,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
    output logic                       o_busy
);

    // Widths of the requester index, the bit-period divider and the
    // per-state bit counter. The bit counter must reach the last header
    // bit (2), the last data bit (3) and the last gap bit (GAP_BITS-1).
    localparam int IW     = $clog2(NUM_REQ);
    localparam int DW     = $clog2(BIT_DIV);
    localparam int MAXBIT = (GAP_BITS > 4) ? (GAP_BITS - 1) : 3;
    localparam int BW     = $clog2(MAXBIT + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(BIT_DIV - 2);
    localparam logic [BW-1:0] HDR_LAST = BW'(2);
    localparam logic [BW-1:0] DAT_LAST = BW'(3);
    localparam logic [BW-1:0] GAP_LAST = BW'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        PAR,
        GAP
    } state_t;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [DW-1:0]       r_div;
    logic [BW-1:0]       r_bit;
    logic [3:0]          r_nibble;
    logic                r_parity;

    // Registered outputs
    logic [NUM_REQ-1:0]  r_reqReady;
    logic                r_txBit;
    logic                r_txActive;
    logic                r_bitStrobe;
    logic [IW-1:0]       r_grantId;
    logic                r_busy;

    // Arbitration results
    logic [IW-1:0]       w_winner;
    logic                w_anyValid;
    logic [3:0]          w_winData;
    logic [NUM_REQ-1:0]  w_grantOneHot;

    assign w_anyValid    = |i_req_valid;
    assign w_winData     = i_req_data[4*w_winner +: 4];
    assign w_grantOneHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;

`ifdef FSK_TX_FIXED_PRIO_EN
    // Fixed priority: scanning from the top down, the last valid index
    // found is the lowest one, which therefore wins.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                w_winner = IW'(i);
            end
        end
    end
`else
    // Round-robin pointer: index of the requester checked first. It moves
    // to one past the winner on every grant so each requester gets a turn.
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_nextPtr;

    assign w_nextPtr = (w_winner == IW'(NUM_REQ - 1)) ? '0 : (w_winner + 1'b1);

    // Walk the requesters starting at the pointer and wrapping past
    // NUM_REQ-1 back to 0; the first valid requester wins.
    always_comb begin
        int  idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && i_req_valid[idx]) begin
                found    = 1'b1;
                w_winner = IW'(idx);
            end
        end
    end

    // The pointer only moves when a grant is issued from IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (r_state == IDLE && w_anyValid) begin
            r_ptr <= w_nextPtr;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Frame sequencer.
    // The outputs are registered, so every transition also loads the
    // output values for the state being entered. bit_strobe is loaded
    // one cycle ahead: it is set when the divider is about to reach
    // BIT_DIV-1, which makes it high exactly on the last clk of a bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_nibble    <= '0;
            r_parity    <= 1'b0;
            r_reqReady  <= '0;
            r_txBit     <= 1'b0;
            r_txActive  <= 1'b0;
            r_bitStrobe <= 1'b0;
            r_grantId   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_reqReady <= '0;
            case (r_state)
                IDLE: begin
                    // Request data and parity are captured here only, so
                    // later changes on i_req_data cannot affect the frame.
                    if (w_anyValid) begin
                        r_reqReady  <= w_grantOneHot;
                        r_grantId   <= w_winner;
                        r_nibble    <= w_winData;
                        r_parity    <= ^w_winData;
                        r_state     <= HDR;
                        r_div       <= '0;
                        r_bit       <= '0;
                        r_txBit     <= 1'b1;
                        r_txActive  <= 1'b1;
                        r_bitStrobe <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end

                default: begin
                    if (r_div != DIV_LAST) begin
                        r_div       <= r_div + 1'b1;
                        r_bitStrobe <= (r_div == DIV_PRE);
                    end else begin
                        // End of a bit period: move to the next bit.
                        r_div       <= '0;
                        r_bitStrobe <= 1'b0;
                        case (r_state)
                            HDR: begin
                                if (r_bit == HDR_LAST) begin
                                    r_state <= DATA;
                                    r_bit   <= '0;
                                    r_txBit <= r_nibble[0];
                                end else begin
                                    r_bit   <= r_bit + 1'b1;
                                    r_txBit <= 1'b1;
                                end
                            end

                            DATA: begin
                                if (r_bit == DAT_LAST) begin
                                    r_state <= PAR;
                                    r_bit   <= '0;
                                    r_txBit <= r_parity;
                                end else begin
                                    r_bit   <= r_bit + 1'b1;
                                    r_txBit <= r_nibble[r_bit[1:0] + 2'd1];
                                end
                            end

                            PAR: begin
                                r_state    <= GAP;
                                r_bit      <= '0;
                                r_txBit    <= 1'b0;
                                r_txActive <= 1'b0;
                            end

                            GAP: begin
                                if (r_bit == GAP_LAST) begin
                                    r_state <= IDLE;
                                    r_bit   <= '0;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_bit <= r_bit + 1'b1;
                                end
                                r_txBit <= 1'b0;
                            end

                            default: begin
                                r_state    <= IDLE;
                                r_bit      <= '0;
                                r_txBit    <= 1'b0;
                                r_txActive <= 1'b0;
                                r_busy     <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign o_req_ready  = r_reqReady;
    assign o_tx_bit     = r_txBit;
    assign o_tx_active  = r_txActive;
    assign o_bit_strobe = r_bitStrobe;
    assign o_grant_id   = r_grantId;
    assign o_busy       = r_busy;

endmodule
